// File: rtl/l1_gan_core_if.sv
// Sample/config/result bundle for l1_gan_core. Flat weight and bias buses carry
// signed 16-bit fields; the result side is driven by the core's output registers.
interface l1_gan_core_if;
    // in_valid marks a sample to capture at the next rising edge; there is no
    // ready, so the core accepts every valid cycle and pulses out_valid one cycle later.
    logic                in_valid;
    logic signed [15:0]  x1, x2, x3, x4;
    logic        [255:0] L1_w;
    logic        [63:0]  L1_b;
    logic        [127:0] L2_w;
    logic        [31:0]  L2_b;
    logic        [31:0]  L3_w;
    logic        [15:0]  L3_b;
    logic        [15:0]  L4_w;
    logic        [15:0]  L4_b;
    logic        [15:0]  L5_w;
    logic        [15:0]  L5_b;
    logic        [31:0]  L6_w;
    logic        [31:0]  L6_b;
    logic        [127:0] L7_w;
    logic        [63:0]  L7_b;
    logic        [255:0] L8_w;
    logic        [63:0]  L8_b;
    logic signed [15:0]  out1, out2, out3, out4;
    logic                out_valid;

    modport master (
        output in_valid, x1, x2, x3, x4,
        output L1_w, L1_b, L2_w, L2_b, L3_w, L3_b, L4_w, L4_b,
        output L5_w, L5_b, L6_w, L6_b, L7_w, L7_b, L8_w, L8_b,
        input  out1, out2, out3, out4, out_valid
    );

    modport slave (
        input  in_valid, x1, x2, x3, x4,
        input  L1_w, L1_b, L2_w, L2_b, L3_w, L3_b, L4_w, L4_b,
        input  L5_w, L5_b, L6_w, L6_b, L7_w, L7_b, L8_w, L8_b,
        output out1, out2, out3, out4, out_valid
    );
endinterface

// File: rtl/l1_gan_core.sv
// Fixed 4-4-2-1-1-2-4-4 integer MLP: combinational layer chain with saturating
// 36-bit accumulation, ReLU on layers 1-7, and a single registered output stage.
module l1_gan_core (
    input  logic          clk,
    input  logic          rst_n,
    l1_gan_core_if.slave  bus
);

    // One layer of up to 4x4 neurons; unused inputs/outputs are zero-padded.
    // Weights for output j are contiguous: w_ij sits at field j*n_in + i.
    function automatic logic [63:0] f_layer(
        input logic [255:0] w,
        input logic [63:0]  b,
        input logic [63:0]  a,
        input int           n_in,
        input int           n_out,
        input logic         relu
    );
        logic [63:0]        y;
        logic signed [35:0] acc;
        logic signed [31:0] prod;
        logic signed [15:0] wv;
        logic signed [15:0] av;
        y = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < n_out) begin
                acc = {{20{b[16*j+15]}}, b[16*j +: 16]};
                for (int i = 0; i < 4; i++) begin
                    if (i < n_in) begin
                        wv   = w[16*(j*n_in+i) +: 16];
                        av   = a[16*i +: 16];
                        prod = wv * av;
                        acc  = acc + {{4{prod[31]}}, prod};
                    end
                end
                if (acc > 36'sd32767)
                    y[16*j +: 16] = 16'h7fff;
                else if (acc < -36'sd32768)
                    y[16*j +: 16] = 16'h8000;
                else
                    y[16*j +: 16] = acc[15:0];
                if (relu && y[16*j+15])
                    y[16*j +: 16] = '0;
            end
        end
        return y;
    endfunction

    logic [63:0] w_h1, w_h2, w_h3, w_h4, w_h5, w_h6, w_h7, w_h8;
    logic [63:0] r_out;
    logic        r_valid;

    assign w_h1 = f_layer(bus.L1_w, bus.L1_b,
                          {bus.x4, bus.x3, bus.x2, bus.x1}, 4, 4, 1'b1);
    assign w_h2 = f_layer({128'd0, bus.L2_w}, {32'd0, bus.L2_b}, w_h1, 4, 2, 1'b1);
    assign w_h3 = f_layer({224'd0, bus.L3_w}, {48'd0, bus.L3_b}, w_h2, 2, 1, 1'b1);
    assign w_h4 = f_layer({240'd0, bus.L4_w}, {48'd0, bus.L4_b}, w_h3, 1, 1, 1'b1);
    assign w_h5 = f_layer({240'd0, bus.L5_w}, {48'd0, bus.L5_b}, w_h4, 1, 1, 1'b1);
    assign w_h6 = f_layer({224'd0, bus.L6_w}, {32'd0, bus.L6_b}, w_h5, 1, 2, 1'b1);
    assign w_h7 = f_layer({128'd0, bus.L7_w}, bus.L7_b, w_h6, 2, 4, 1'b1);
    assign w_h8 = f_layer(bus.L8_w, bus.L8_b, w_h7, 4, 4, 1'b0);

    // Outputs hold across idle cycles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid)
                r_out <= w_h8;
        end
    end

    assign bus.out1      = r_out[15:0];
    assign bus.out2      = r_out[31:16];
    assign bus.out3      = r_out[47:32];
    assign bus.out4      = r_out[63:48];
    assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_l1_gan_core.sv
// Self-checking bench for l1_gan_core: directed vectors with hand-derived results,
// a reference model for random traffic, and reset behaviour checks.
module tb_l1_gan_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    l1_gan_core_if bif();
    l1_gan_core dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] got;
    logic [63:0] last_out;

    int n_in[8]  = '{4, 4, 2, 1, 1, 1, 2, 4};
    int n_out[8] = '{4, 2, 1, 1, 1, 2, 4, 4};
    int wt[8][4][4];
    int bs[8][4];
    int xv[4];

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic cfg_clear();
        for (int l = 0; l < 8; l++)
            for (int j = 0; j < 4; j++) begin
                bs[l][j] = 0;
                for (int i = 0; i < 4; i++) wt[l][i][j] = 0;
            end
        for (int i = 0; i < 4; i++) xv[i] = 0;
    endtask

    task automatic set_col(input int l, input int j, input int a, input int b, input int c, input int d);
        wt[l][0][j] = a; wt[l][1][j] = b; wt[l][2][j] = c; wt[l][3][j] = d;
    endtask

    task automatic set_b(input int l, input int a, input int b, input int c, input int d);
        bs[l][0] = a; bs[l][1] = b; bs[l][2] = c; bs[l][3] = d;
    endtask

    // Packs the arrays onto the buses: w_ij at field (j-1)*N + (i-1).
    task automatic apply();
        logic [255:0] tw;
        logic [63:0]  tbv;
        for (int l = 0; l < 8; l++) begin
            tw  = '0;
            tbv = '0;
            for (int j = 0; j < n_out[l]; j++) begin
                tbv[16*j +: 16] = 16'(bs[l][j]);
                for (int i = 0; i < n_in[l]; i++)
                    tw[16*(j*n_in[l]+i) +: 16] = 16'(wt[l][i][j]);
            end
            case (l)
                0: begin bif.L1_w = tw;         bif.L1_b = tbv;        end
                1: begin bif.L2_w = tw[127:0];  bif.L2_b = tbv[31:0];  end
                2: begin bif.L3_w = tw[31:0];   bif.L3_b = tbv[15:0];  end
                3: begin bif.L4_w = tw[15:0];   bif.L4_b = tbv[15:0];  end
                4: begin bif.L5_w = tw[15:0];   bif.L5_b = tbv[15:0];  end
                5: begin bif.L6_w = tw[31:0];   bif.L6_b = tbv[31:0];  end
                6: begin bif.L7_w = tw[127:0];  bif.L7_b = tbv;        end
                default: begin bif.L8_w = tw;   bif.L8_b = tbv;        end
            endcase
        end
        bif.x1 = 16'(xv[0]); bif.x2 = 16'(xv[1]);
        bif.x3 = 16'(xv[2]); bif.x4 = 16'(xv[3]);
    endtask

    function automatic logic [63:0] model();
        longint a[4];
        longint nx[4];
        longint acc;
        for (int i = 0; i < 4; i++) a[i] = longint'(xv[i]);
        for (int l = 0; l < 8; l++) begin
            for (int j = 0; j < 4; j++) nx[j] = 0;
            for (int j = 0; j < n_out[l]; j++) begin
                acc = longint'(bs[l][j]);
                for (int i = 0; i < n_in[l]; i++)
                    acc += longint'(wt[l][i][j]) * a[i];
                if (acc > 32767)  acc = 32767;
                if (acc < -32768) acc = -32768;
                if (l < 7 && acc < 0) acc = 0;
                nx[j] = acc;
            end
            for (int j = 0; j < 4; j++) a[j] = nx[j];
        end
        return pk(int'(a[0]), int'(a[1]), int'(a[2]), int'(a[3]));
    endfunction

    task automatic cfg_bias();
        cfg_clear();
        set_b(7, -10, 10, 10, -10);
        for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 2000)) - 1000;
    endtask

    task automatic cfg_linear(input int x1);
        cfg_clear();
        wt[0][0][0] = 1; wt[1][0][0] = 1; wt[2][0][0] = 1; wt[3][0][0] = 1; wt[4][0][0] = 1;
        wt[5][0][0] = 1; wt[5][0][1] = 1;
        for (int j = 0; j < 4; j++) wt[6][0][j] = 1;
        wt[7][0][0] = 1; wt[7][1][1] = -1; wt[7][2][2] = 2; wt[7][3][3] = 0;
        bs[7][3] = 3;
        xv[0] = x1;
        xv[1] = int'($urandom_range(0, 200)) - 100;
        xv[2] = int'($urandom_range(0, 200)) - 100;
        xv[3] = int'($urandom_range(0, 200)) - 100;
    endtask

    task automatic cfg_corner();
        cfg_clear();
        xv[0] = 0; xv[1] = 1; xv[2] = 1; xv[3] = 0;
        set_col(0, 0, 6, -3, 5, -16);  set_col(0, 1, 21, 16, -6, -9);
        set_col(0, 2, 3, -3, -15, -17); set_col(0, 3, 18, 12, -4, -8);
        set_b(0, 1, 0, 2, -1);
        set_col(1, 0, 4, 14, 8, 15);   set_col(1, 1, -14, 14, 9, 15);
        set_b(1, 1, 4, 0, 0);
        set_col(2, 0, 14, 6, 0, 0);    set_b(2, 5, 0, 0, 0);
        wt[3][0][0] = 7;  set_b(3, 10, 0, 0, 0);
        wt[4][0][0] = 1;  set_b(4, -4, 0, 0, 0);
        wt[5][0][0] = -8; wt[5][0][1] = 14; set_b(5, 20, 0, 0, 0);
        set_col(6, 0, 4, -14, 0, 0);   set_col(6, 1, 14, 14, 0, 0);
        set_col(6, 2, 8, 9, 0, 0);     set_col(6, 3, 15, 15, 0, 0);
        set_b(6, 5, 3, 1, 2);
        set_col(7, 0, 11, 9, 10, 1);   set_col(7, 1, -7, -6, -15, 17);
        set_col(7, 2, 10, 11, -5, 4);  set_col(7, 3, -7, -7, 7, 12);
        set_b(7, -10, 10, 10, -10);
    endtask

    task automatic cfg_random();
        bit big;
        big = ($urandom_range(0, 3) == 0);
        for (int l = 0; l < 8; l++)
            for (int j = 0; j < 4; j++) begin
                bs[l][j] = big ? int'($urandom_range(0, 65535)) - 32768
                               : int'($urandom_range(0, 40)) - 20;
                for (int i = 0; i < 4; i++)
                    wt[l][i][j] = big ? int'($urandom_range(0, 65535)) - 32768
                                      : int'($urandom_range(0, 16)) - 8;
            end
        for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 400)) - 200;
    endtask

    // Presents the current configuration with in_valid high and steps one edge.
    task automatic drive_valid(input logic [63:0] expected);
        bif.in_valid = 1'b1;
        apply();
        exp_q.push_back(expected);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        cfg_corner();
        bif.in_valid = 1'b1;
        apply();
        repeat (3) @(posedge clk);
        #1;
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== 64'd0) begin
            n_err++; $display("FAIL reset_out: got %h required %h", got, 64'd0);
        end
        n_cmp++;
        if (bif.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b required 0", bif.out_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        drive_valid(pk(32767, -32768, 32767, 32767));
        exp_v = exp_q.pop_front();
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL first_capture: got %h required %h", got, exp_v);
        end
        n_cmp++;
        if (bif.out_valid !== 1'b1) begin
            n_err++; $display("FAIL first_valid: got %b required 1", bif.out_valid);
        end
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (bif.out_valid !== 1'b0) begin
            n_err++; $display("FAIL valid_pulse: got %b required 0", bif.out_valid);
        end
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL idle_hold: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_bias();
        cfg_bias();
        drive_valid(pk(-10, 10, 10, -10));
        exp_v = exp_q.pop_front();
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL bias_pass: got %h required %h", got, exp_v);
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic test_linear();
        cfg_linear(5);
        drive_valid(pk(5, -5, 10, 3));
        cfg_linear(-5);
        drive_valid(pk(0, 0, 0, 3));
        bif.in_valid = 1'b0;
        // First result is already in the output register; second lands above.
        exp_v = exp_q.pop_front();
        exp_v = exp_q.pop_front();
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL linear_neg: got %h required %h", got, exp_v);
        end
        cfg_linear(5);
        drive_valid(pk(5, -5, 10, 3));
        bif.in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL linear_pos: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_corner();
        cfg_corner();
        drive_valid(pk(32767, -32768, 32767, 32767));
        bif.in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL corner_sat: got %h required %h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                cfg_linear(5);
                drive_valid(pk(5, -5, 10, 3));
            end else begin
                cfg_corner();
                drive_valid(pk(32767, -32768, 32767, 32767));
            end
            exp_v = exp_q.pop_front();
            got = {bif.out4, bif.out3, bif.out2, bif.out1};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL b2b_out[%0d]: got %h required %h", k, got, exp_v);
            end
            n_cmp++;
            if (bif.out_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b_valid[%0d]: got %b required 1", k, bif.out_valid);
            end
        end
        bif.in_valid = 1'b0;
        last_out = exp_v;
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                cfg_random();
                drive_valid(model());
                exp_v = exp_q.pop_front();
                last_out = exp_v;
                got = {bif.out4, bif.out3, bif.out2, bif.out1};
                n_cmp++;
                if (got !== exp_v) begin
                    n_err++; $display("FAIL rand_out[%0d]: got %h required %h", k, got, exp_v);
                end
                n_cmp++;
                if (bif.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL rand_valid[%0d]: got %b required 1", k, bif.out_valid);
                end
            end else begin
                bif.in_valid = 1'b0;
                cfg_random();
                apply();
                @(posedge clk); #1;
                got = {bif.out4, bif.out3, bif.out2, bif.out1};
                n_cmp++;
                if (got !== last_out || bif.out_valid !== 1'b0) begin
                    n_err++; $display("FAIL rand_idle[%0d]: got %h/%b required %h/0", k, got, bif.out_valid, last_out);
                end
            end
        end
        bif.in_valid = 1'b0;
    endtask

    task automatic test_midreset();
        cfg_corner();
        drive_valid(pk(32767, -32768, 32767, 32767));
        exp_v = exp_q.pop_front();
        cfg_linear(5);
        bif.in_valid = 1'b1;
        apply();
        #2 rst_n = 1'b0;
        #1;
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== 64'd0 || bif.out_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got %h/%b required 0/0", got, bif.out_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        got = {bif.out4, bif.out3, bif.out2, bif.out1};
        n_cmp++;
        if (got !== 64'd0 || bif.out_valid !== 1'b0) begin
            n_err++; $display("FAIL pending_discard: got %h/%b required 0/0", got, bif.out_valid);
        end
    endtask

    initial begin
        bif.in_valid = 1'b0;
        cfg_clear();
        apply();
        test_reset();
        test_bias();
        test_linear();
        test_corner();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_gan_core.md
Name: l1_gan_core

Overview:
- Fully parameter-free, fixed-topology 8-layer integer MLP generator/autoencoder, layer widths 4-4-2-1-1-2-4-4.
- Computes all layers combinationally from a registered-capture view. Result is registered on the clock, with a valid flag.
- Sits downstream of the feature source; all weights and biases arrive as flat signed buses from a host/configuration block.

Parameters:
- none (data width fixed at 16-bit signed two's complement; accumulator fixed at 36 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample x1..x4 and all weights/biases this cycle
- x1, x2, x3, x4  in  16 each  signed inputs
- L1_w  in  256  signed 4x4 weights; L1_b  in  64  signed 4 biases
- L2_w  in  128  4x2; L2_b  in  32
- L3_w  in  32  2x1; L3_b  in  16
- L4_w  in  16  1x1; L4_b  in  16
- L5_w  in  16  1x1; L5_b  in  16
- L6_w  in  32  1x2; L6_b  in  32
- L7_w  in  128  2x4; L7_b  in  64
- L8_w  in  256  4x4; L8_b  in  64
- out1, out2, out3, out4  out  16 each  signed registered results
- out_valid  out  1  high one cycle after an accepted in_valid

Behaviour:
- Packing for a layer with N inputs and M outputs:
  - weight w_ij (input i, output j, 1-based) occupies bits [16*((j-1)*N+(i-1)) +: 16];
  - bias b_j occupies [16*(j-1) +: 16].
  - Example: L1_w[15:0]=w11, [31:16]=w21, [63:48]=w41, [79:64]=w12.
- Neuron: acc_j = sum_i (w_ij * a_i) + b_j.
  - Use full-precision 32-bit signed products.
  - Use a 36-bit signed accumulator; no intermediate wrap.
- Saturation: each acc_j is clamped to [-32768, 32767] to form the 16-bit neuron value.
- Activation:
  - Layers 1-7: ReLU on the saturated value (negative becomes 0).
  - Layer 8: linear, saturated only.
- Chain:
  - layer 1 input = (x1..x4), 4 outputs;
  - L2: 4 to 2; L3: 2 to 1; L4: 1 to 1; L5: 1 to 1; L6: 1 to 2; L7: 2 to 4; L8: 4 to 4.
  - Layer-8 outputs 1..4 map to out1..out4.
- Timing:
  - The whole datapath is combinational from the inputs.
  - On a rising clk with in_valid=1, the layer-8 results are captured into out1..out4, and out_valid is set to 1.
  - On a rising clk with in_valid=0, out1..out4 hold their values and out_valid goes to 0.
  - Latency is 1 cycle. Throughput is one sample per cycle; back-to-back in_valid is allowed.
- Inputs are required stable only around the capture edge. Weights may change every cycle and are used as presented in the accepting cycle.
- Reset:
  - rst_n=0 immediately (asynchronously) forces out1..out4 = 0 and out_valid = 0.
  - While rst_n is low, in_valid is ignored.
  - The first capture happens at the first rising edge with rst_n=1 and in_valid=1.
  - Reset asserted mid-stream discards the pending result.
- Behaviour is fully determined for all input values; there are no illegal encodings.

Test Plan:
- Reset: hold rst_n=0 while driving nonzero inputs with in_valid=1 -> out1..4=0, out_valid=0. Deassert and pulse in_valid -> result appears one edge later with out_valid=1 for exactly one cycle.
- Bias pass-through: all weights 0, L8_b=(b1..b4)=(-10,10,10,-10), any x -> out=(-10,10,10,-10).
- Linear path, no saturation. Program:
  - L1 w11=1, L2 w11=1, L3 w11=1, L4 w11=1, L5 w11=1;
  - L6 w11=w12=1; L7 w11=w12=w13=w14=1;
  - L8 w11=1, w22=-1, w33=2, w44=0;
  - L8 b4=3; all other weights and biases 0.
  - x1=5 -> out=(5,-5,10,3).
  - Same config, x1=-5 -> layer-1 ReLU zeroes the value -> out=(0,0,0,3).
- Saturation and ReLU corner vector:
  - x=(0,1,1,0).
  - L1 rows by output j, listed as (w1j,w2j,w3j,w4j): (6,-3,5,-16), (21,16,-6,-9), (3,-3,-15,-17), (18,12,-4,-8); L1_b=(1,0,2,-1).
  - L2: (4,14,8,15), (-14,14,9,15); L2_b=(1,4).
  - L3 (14,6), b=5. L4 w=7, b=10. L5 w=1, b=-4.
  - L6 (-8),(14); b=(20,0).
  - L7 (4,-14),(14,14),(8,9),(15,15); b=(5,3,1,2).
  - L8 (11,9,10,1),(-7,-6,-15,17),(10,11,-5,4),(-7,-7,7,12); b=(-10,10,10,-10).
  - Expected internals: h1=(3,10,0,7), h2=(258,207), h3=4859, h4=32767 (clamped from 34023).
  - Expected out=(32767,-32768,32767,32767).
- Back-to-back: alternate the previous two configs/vectors with in_valid held high -> each result appears exactly one cycle after its input. out_valid stays high throughout.
